// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   NOP_INSTR        - word presented on InstrF while the buffer is empty (bubble)
//   RESET_PC_DEFAULT - default PC loaded by reset
//   fetch_entry_t    - one buffered fetch: {pcplus4, instr}
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pcplus4;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bundle.
//   imem_req    master->slave  request valid
//   imem_addr   master->slave  word-aligned fetch address
//   imem_ready  slave->master  request accepted at posedge when imem_req & imem_ready
//   imem_rvalid slave->master  read data valid (in order, >=1 cycle after acceptance)
//   imem_rdata  slave->master  instruction word
// Handshake: a request transfers only on a clock edge where imem_req and
// imem_ready are both high. An unaccepted request may change its address
// (the memory is SRAM-style). Responses carry no ready: the master always
// takes imem_rvalid, which is why the master never issues beyond its buffer credit.
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t used as the fetch buffer.
//   clk, rst_n  clock, synchronous active-low reset
//   push        write push_data (caller guarantees space)
//   pop         consume head when non-empty
//   flush       empty the FIFO; overrides push and pop
//   head        combinational head entry (undefined when count==0)
//   count       current occupancy, 0..DEPTH
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [AW:0]  count
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_pop;

    always_comb begin
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push)   wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (AW+1)'(push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage. Owns the PC, issues in-order word fetches, buffers
// returned words and presents the buffer head to the IF/ID register.
//   CLK, Reset          clock, synchronous active-low reset
//   StallF              hold head, no pop, ignore redirects
//   PCSrcD/PCBranchD    taken branch from ID and its target
//   JumpD/PCJumpD       jump from ID and its target (wins over branch)
//   imem                instruction-memory master port (fetch_unit_if)
//   InstrF/PcPlus4F     head instruction and its address+4; 0 when empty
//   FetchValidF         buffer non-empty
// Optional macro FETCH_PERF_CNT_EN adds BubbleCntF (cycles with !StallF and
// an empty buffer) and RedirectCntF (redirects taken).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        StallF,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    input  logic        JumpD,
    input  logic [31:0] PCJumpD,
    fetch_unit_if.master imem,
    output logic [31:0] InstrF,
    output logic [31:0] PcPlus4F,
    output logic        FetchValidF
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] BubbleCntF,
    output logic [31:0] RedirectCntF
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [31:0]  pc_q, pc_d;
    logic [31:0]  resp_pc_q, resp_pc_d;
    logic [AW:0]  outst_q, outst_d;
    logic [AW:0]  drop_q, drop_d;
    logic [AW:0]  count;
    logic [AW+1:0] credits_used;
    fetch_entry_t head, push_data;
    logic         pop, redirect, req, accept, resp, discard, push;
    logic [31:0]  target;

    always_comb begin
        pop      = !StallF && (count != '0);
        redirect = !StallF && (JumpD || PCSrcD);
        target   = JumpD ? PCJumpD : PCBranchD;
        // Buffered + in-flight words may never exceed the buffer, so every
        // response has a slot waiting for it.
        credits_used = {1'b0, count} + {1'b0, outst_q} - (AW+2)'(pop);
        req      = Reset && (credits_used < (AW+2)'(FIFO_DEPTH));
        accept   = req && imem.imem_ready;
        // Responses with nothing outstanding belong to requests abandoned by reset.
        resp     = imem.imem_rvalid && (outst_q != '0);
        discard  = resp && (drop_q != '0);
        push     = resp && !discard && !redirect;
        push_data.pcplus4 = resp_pc_q + 32'd4;
        push_data.instr   = imem.imem_rdata;

        outst_d = outst_q + (AW+1)'(accept) - (AW+1)'(resp);
        drop_d  = drop_q;
        if (discard) drop_d = drop_q - 1'b1;
        // Everything still in flight after this edge is old-stream, including
        // words already being dropped, so the drop count becomes the new total.
        if (redirect) drop_d = outst_d;

        pc_d = pc_q;
        if (redirect)    pc_d = target;
        else if (accept) pc_d = pc_q + 32'd4;

        resp_pc_d = resp_pc_q;
        if (redirect)  resp_pc_d = target;
        else if (push) resp_pc_d = resp_pc_q + 32'd4;
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            pc_q      <= RESET_PC;
            resp_pc_q <= RESET_PC;
            outst_q   <= '0;
            drop_q    <= '0;
        end else begin
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            outst_q   <= outst_d;
            drop_q    <= drop_d;
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (CLK),
        .rst_n    (Reset),
        .push     (push),
        .push_data(push_data),
        .pop      (pop),
        .flush    (redirect),
        .head     (head),
        .count    (count)
    );

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;
    assign FetchValidF    = (count != '0);
    assign InstrF         = FetchValidF ? head.instr   : NOP_INSTR;
    assign PcPlus4F       = FetchValidF ? head.pcplus4 : 32'h0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] bubble_q, bubble_d, redir_q, redir_d;

    always_comb begin
        bubble_d = bubble_q;
        redir_d  = redir_q;
        if (!StallF && (count == '0)) bubble_d = bubble_q + 32'd1;
        if (redirect)                 redir_d  = redir_q + 32'd1;
    end

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            bubble_q <= '0;
            redir_q  <= '0;
        end else begin
            bubble_q <= bubble_d;
            redir_q  <= redir_d;
        end
    end

    assign BubbleCntF   = bubble_q;
    assign RedirectCntF = redir_q;
`endif

endmodule
